pipe_hazard_unit: RTL and testbench
===================================

// Module: pipe_hazard_unit
// PURPOSE
//  Hazard/forwarding controller for the 5-stage pipelined CPU. Tracks destination regs of in-flight
//  instructions in an internal shadow pipeline (EX/MEM/WB), raises load-use/RAW stalls, issues branch
//  flushes when a taken branch resolves in MEM, and drives registered forwarding selects for the EX
//  operand muxes. Configurable for forwarding on/off and register-file write-through on/off.
// PARAMETERS
//  REG_AW    5   register address width
//  FWD_EN    1   1: EX/MEM and MEM/WB forwarding; 0: stall on every RAW until the write retires
//  RF_WT     1   1: register file passes same-cycle write to read; 0: hazard vs WB entry also stalls
//  CNT_W     16  width of stall/flush performance counters
// PORTS
//  clk_i            in   1       clock, rising edge
//  rst_i            in   1       reset: synchronous, active-high
//  id_valid_i       in   1       ID stage holds a real instruction
//  id_rs_i          in   REG_AW  ID source rs
//  id_rt_i          in   REG_AW  ID source rt
//  id_use_rs_i      in   1       ID instruction reads rs
//  id_use_rt_i      in   1       ID instruction reads rt
//  id_wr_en_i       in   1       ID instruction writes a register (RegWrite)
//  id_wr_addr_i     in   REG_AW  ID destination (post-RegDst mux value)
//  id_is_load_i     in   1       ID instruction is a load (MemRead)
//  mem_br_taken_i   in   1       branch in MEM is taken (Branch & zero)
//  stall_o          out  1       hold PC and IF/ID; insert bubble into ID/EX
//  flush_o          out  1       squash IF/ID, ID/EX, EX/MEM contents
//  fwd_a_o          out  2       EX src1 select: 00 RF, 01 EX/MEM ALU result, 10 MEM/WB write data
//  fwd_b_o          out  2       EX src2 select, same encoding
//  stall_cnt_o      out  CNT_W   saturating count of stall cycles
//  flush_cnt_o      out  CNT_W   saturating count of flush events
// BEHAVIOUR
//  - Shadow entry per stage {v, wr_en, addr, is_load}; entry "writes r" iff v & wr_en & addr==r & r!=0.
//  - Register 0 never creates a hazard or a forward.
//  - stall_o (comb.), only when id_valid_i & !mem_br_taken_i, for any used source r:
//     FWD_EN=1: EX entry writes r and EX.is_load (load-use, exactly 1 bubble).
//     FWD_EN=0: EX or MEM entry writes r.
//     RF_WT=0 (either mode): WB entry writes r also stalls.
//  - flush_o = mem_br_taken_i (comb., same cycle). Flush beats stall: stall_o forced 0 when flushing.
//  - Clock update: WB<=MEM; MEM<= flush ? invalid : EX; EX<= (flush|stall|!id_valid_i) ? invalid : ID.
//  - fwd_a_o/fwd_b_o registered, loaded with EX entry: computed from ID sources at the ID->EX advance:
//     01 if EX entry writes r (it will be in MEM), else 10 if MEM entry writes r (will be in WB), else 00.
//     EX match has priority over MEM. Bubble/flush/FWD_EN=0/unused source -> 00.
//  - Latency: stall/flush 0 cycles (comb.); fwd selects valid the cycle the instruction sits in EX.
//  - Counters: +1 per cycle stall_o=1, +1 per cycle flush_o=1; saturate at all-ones, no wrap.
//  - Reset (sync, rst_i=1): all shadow entries invalid, fwd_a_o=fwd_b_o=00, counters 0; stall_o=flush_o=0
//    while in reset. Reset mid-stall aborts the stall; first post-reset cycle sees an empty pipeline.
//  - id inputs ignored when id_valid_i=0; no X propagation from unused source fields.
// STRUCTURE
//  - Shared package pipe_pkg: REG_AW default, FWD_RF/FWD_EXMEM/FWD_MEMWB 2-bit encodings,
//    shadow-entry struct typedef.
//  - One sub-module: pipe_hz_cmp (single source vs. three shadow entries -> hit_ex, hit_mem, hit_wb,
//    load_hit); instantiated twice (rs, rt). Counters inline.
// TESTING
//  1 add r3,r1,r2 ; sub r5,r3,r4 (FWD_EN=1) -> no stall; sub in EX sees fwd_a_o=01, fwd_b_o=00.
//  2 lw r3,0(r1) ; add r5,r3,r3 -> stall_o=1 one cycle, bubble into EX; then fwd_a_o=fwd_b_o=10; stall_cnt_o=1.
//  3 add r0,r1,r2 ; add r4,r0,r0 -> no stall, fwd selects 00 (r0 exempt).
//  4 beq taken in MEM while lw/use stall pending in ID -> flush_o=1, stall_o=0, EX/MEM shadow invalid
//    next cycle, flush_cnt_o=1.
//  5 FWD_EN=0, RF_WT=0: add r3,.. ; add r6,r3,.. -> stall_o=1 for 3 cycles, fwd selects 00 throughout.
//  6 rst_i=1 mid-stall -> next cycle stall_o=0, counters 0; force counters near 2^CNT_W-1 -> hold at max.

Source files
------------

// File: rtl/pipe_hazard_unit_pkg.sv
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline hazard unit:
//               forwarding-select encodings, shadow-pipeline entry struct
//               and small helpers used by the comparator and top level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    // Default register address width of the CPU register file.
    localparam int REG_AW_DEF = 5;
    // Storage width of a shadow-entry address; REG_AW must not exceed this.
    localparam int REG_AW_MAX = 8;

    // EX operand mux select encodings.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                  v;
        logic                  wr_en;
        logic [REG_AW_MAX-1:0] addr;
        logic                  is_load;
    } shadow_t;

    // True when the entry will write register r; r0 is never a producer.
    function automatic logic entry_writes(input shadow_t e, input logic [REG_AW_MAX-1:0] r);
        return e.v && e.wr_en && (e.addr == r) && (r != '0);
    endfunction

    // Youngest producer wins: the EX entry holds the newer value than MEM.
    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem);
        if (hit_ex) begin
            return FWD_EXMEM;
        end else if (hit_mem) begin
            return FWD_MEMWB;
        end
        return FWD_RF;
    endfunction

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/pipe_hazard_unit_if.sv
// ============================================================================
// Module      : pipe_hazard_unit_if
// Description : ID-stage request / hazard-control response bundle between
//               the CPU datapath (master) and the hazard unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs_i;
    logic [REG_AW-1:0] id_rt_i;
    logic              id_use_rs_i;
    logic              id_use_rt_i;
    logic              id_wr_en_i;
    logic [REG_AW-1:0] id_wr_addr_i;
    logic              id_is_load_i;
    logic              mem_br_taken_i;
    logic              stall_o;
    logic              flush_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_wr_en_i, id_wr_addr_i, id_is_load_i, mem_br_taken_i,
        input  stall_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
               id_wr_en_i, id_wr_addr_i, id_is_load_i, mem_br_taken_i,
        output stall_o, flush_o, fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
    );

endinterface : pipe_hazard_unit_if

`default_nettype wire

// File: rtl/pipe_hazard_unit_cmp.sv
// ============================================================================
// Module      : pipe_hz_cmp
// Description : Compares one ID source register against the EX, MEM and WB
//               shadow entries and reports which stages will write it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hz_cmp
    import pipe_pkg::*;
(
    input  logic [REG_AW_MAX-1:0] src_i,
    input  logic                  use_i,
    input  shadow_t               ex_i,
    input  shadow_t               mem_i,
    input  shadow_t               wb_i,
    output logic                  hit_ex_o,
    output logic                  hit_mem_o,
    output logic                  hit_wb_o,
    output logic                  load_hit_o
);
    // An unused source is folded onto r0, which can never match, so stale or
    // undriven source fields cannot create a hazard or leak X.
    logic [REG_AW_MAX-1:0] w_src;

    assign w_src      = use_i ? src_i : '0;
    assign hit_ex_o   = entry_writes(ex_i,  w_src);
    assign hit_mem_o  = entry_writes(mem_i, w_src);
    assign hit_wb_o   = entry_writes(wb_i,  w_src);
    assign load_hit_o = hit_ex_o && ex_i.is_load;

endmodule : pipe_hz_cmp

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
// ============================================================================
// Module      : pipe_hazard_unit
// Description : Hazard / forwarding controller for a 5-stage pipeline. Keeps
//               a shadow EX/MEM/WB copy of destination registers, raises
//               RAW/load-use stalls, flushes on a taken branch in MEM and
//               registers the EX operand forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_unit
    import pipe_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int FWD_EN = 1,
    parameter int RF_WT  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    pipe_hazard_unit_if.slave bus
);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    shadow_t               ex_q, mem_q, wb_q;
    logic [1:0]            fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic [CNT_W-1:0]      stall_cnt_q, flush_cnt_q;

    shadow_t               w_id_entry;
    logic [REG_AW_MAX-1:0] w_rs, w_rt;
    logic                  w_use_rs, w_use_rt;
    logic                  w_rs_ex, w_rs_mem, w_rs_wb, w_rs_load;
    logic                  w_rt_ex, w_rt_mem, w_rt_wb, w_rt_load;
    logic                  w_raw_pipe, w_raw_wb;
    logic                  w_stall, w_flush, w_advance;

    assign w_rs     = REG_AW_MAX'(bus.id_rs_i);
    assign w_rt     = REG_AW_MAX'(bus.id_rt_i);
    assign w_use_rs = bus.id_valid_i && bus.id_use_rs_i;
    assign w_use_rt = bus.id_valid_i && bus.id_use_rt_i;

    assign w_id_entry = '{v:       bus.id_valid_i,
                          wr_en:   bus.id_wr_en_i,
                          addr:    REG_AW_MAX'(bus.id_wr_addr_i),
                          is_load: bus.id_is_load_i};

    pipe_hz_cmp u_cmp_rs (
        .src_i      (w_rs),
        .use_i      (w_use_rs),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .hit_ex_o   (w_rs_ex),
        .hit_mem_o  (w_rs_mem),
        .hit_wb_o   (w_rs_wb),
        .load_hit_o (w_rs_load)
    );

    pipe_hz_cmp u_cmp_rt (
        .src_i      (w_rt),
        .use_i      (w_use_rt),
        .ex_i       (ex_q),
        .mem_i      (mem_q),
        .wb_i       (wb_q),
        .hit_ex_o   (w_rt_ex),
        .hit_mem_o  (w_rt_mem),
        .hit_wb_o   (w_rt_wb),
        .load_hit_o (w_rt_load)
    );

    // With forwarding only an EX-stage load is too late to bypass; without it
    // every pending producer in EX or MEM must retire first. A WB producer is
    // only a hazard when the register file cannot pass a same-cycle write.
    assign w_raw_pipe = (FWD_EN != 0) ? (w_rs_load || w_rt_load)
                                      : (w_rs_ex || w_rs_mem || w_rt_ex || w_rt_mem);
    assign w_raw_wb   = (RF_WT == 0) && (w_rs_wb || w_rt_wb);

    // Flush has priority over stall; both are held low during reset.
    assign w_flush   = !rst_i && bus.mem_br_taken_i;
    assign w_stall   = !rst_i && bus.id_valid_i && !bus.mem_br_taken_i
                       && (w_raw_pipe || w_raw_wb);
    assign w_advance = bus.id_valid_i && !w_flush && !w_stall;

    // Forwarding selects for the instruction about to enter EX.
    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if ((FWD_EN != 0) && w_advance) begin
            fwd_a_d = fwd_sel(w_rs_ex, w_rs_mem);
            fwd_b_d = fwd_sel(w_rt_ex, w_rt_mem);
        end
    end

    // Shadow pipeline advance, registered selects and saturating counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            fwd_a_q     <= FWD_RF;
            fwd_b_q     <= FWD_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= w_flush ? shadow_t'('0) : ex_q;
            ex_q    <= w_advance ? w_id_entry : shadow_t'('0);
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            if (w_stall && (stall_cnt_q != c_cnt_max)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (w_flush && (flush_cnt_q != c_cnt_max)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall_o     = w_stall;
    assign bus.flush_o     = w_flush;
    assign bus.fwd_a_o     = fwd_a_q;
    assign bus.fwd_b_o     = fwd_b_q;
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;

endmodule : pipe_hazard_unit

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
// ============================================================================
// Module      : tb_pipe_hazard_unit
// Description : Directed self-checking bench. Instance A: forwarding on,
//               register-file write-through on, 16-bit counters. Instance B:
//               forwarding off, write-through off, 2-bit counters so that
//               counter saturation is reachable with a few stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_unit;

    logic clk_i = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk_i = ~clk_i;

    pipe_hazard_unit_if #(.REG_AW(5), .CNT_W(16)) ifa ();
    pipe_hazard_unit_if #(.REG_AW(5), .CNT_W(2))  ifb ();

    pipe_hazard_unit #(.REG_AW(5), .FWD_EN(1), .RF_WT(1), .CNT_W(16)) dut_a (
        .clk_i (clk_i),
        .rst_i (rst_a),
        .bus   (ifa)
    );

    pipe_hazard_unit #(.REG_AW(5), .FWD_EN(0), .RF_WT(0), .CNT_W(2)) dut_b (
        .clk_i (clk_i),
        .rst_i (rst_b),
        .bus   (ifb)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and move #1 past the edge before driving/sampling.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic id_a(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] wa, input logic ld);
        ifa.id_valid_i   = v;
        ifa.id_rs_i      = rs;
        ifa.id_rt_i      = rt;
        ifa.id_use_rs_i  = urs;
        ifa.id_use_rt_i  = urt;
        ifa.id_wr_en_i   = we;
        ifa.id_wr_addr_i = wa;
        ifa.id_is_load_i = ld;
    endtask

    task automatic id_b(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic we,
                        input logic [4:0] wa, input logic ld);
        ifb.id_valid_i   = v;
        ifb.id_rs_i      = rs;
        ifb.id_rt_i      = rt;
        ifb.id_use_rs_i  = urs;
        ifb.id_use_rt_i  = urt;
        ifb.id_wr_en_i   = we;
        ifb.id_wr_addr_i = wa;
        ifb.id_is_load_i = ld;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        id_a(0, 0, 0, 0, 0, 0, 0, 0);
        id_b(0, 0, 0, 0, 0, 0, 0, 0);
        ifa.mem_br_taken_i = 1'b0;
        ifb.mem_br_taken_i = 1'b0;
        step();
        step();

        // ---- reset state, instance A ----
        chk("rst_stall",     ifa.stall_o,     0);
        chk("rst_flush",     ifa.flush_o,     0);
        chk("rst_fwd_a",     ifa.fwd_a_o,     0);
        chk("rst_fwd_b",     ifa.fwd_b_o,     0);
        chk("rst_stall_cnt", ifa.stall_cnt_o, 0);
        chk("rst_flush_cnt", ifa.flush_cnt_o, 0);
        ifa.mem_br_taken_i = 1'b1;
        #1;
        chk("rst_flush_gated", ifa.flush_o, 0);
        ifa.mem_br_taken_i = 1'b0;
        step();
        rst_a = 1'b0;

        // ---- 1: add r3,r1,r2 ; sub r5,r3,r4 -> EX/MEM forward on rs ----
        id_a(1, 1, 2, 1, 1, 1, 3, 0);
        #1;
        chk("t1_add_stall", ifa.stall_o, 0);
        step();
        id_a(1, 3, 4, 1, 1, 1, 5, 0);
        #1;
        chk("t1_sub_stall", ifa.stall_o, 0);
        step();
        id_a(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t1_fwd_a", ifa.fwd_a_o, 2'b01);
        chk("t1_fwd_b", ifa.fwd_b_o, 2'b00);
        step(); step(); step();

        // ---- 2: lw r3,0(r1) ; add r5,r3,r3 -> one bubble, then MEM/WB forward ----
        id_a(1, 1, 3, 1, 0, 1, 3, 1);
        #1;
        chk("t2_lw_stall", ifa.stall_o, 0);
        step();
        id_a(1, 3, 3, 1, 1, 1, 5, 0);
        #1;
        chk("t2_loaduse_stall", ifa.stall_o, 1);
        step();
        #1;
        chk("t2_stall_released", ifa.stall_o,     0);
        chk("t2_stall_cnt",      ifa.stall_cnt_o, 1);
        chk("t2_bubble_fwd_a",   ifa.fwd_a_o,     2'b00);
        step();
        id_a(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t2_fwd_a", ifa.fwd_a_o, 2'b10);
        chk("t2_fwd_b", ifa.fwd_b_o, 2'b10);
        step(); step(); step();

        // ---- 3: add r0,r1,r2 ; add r4,r0,r0 -> r0 exempt ----
        id_a(1, 1, 2, 1, 1, 1, 0, 0);
        step();
        id_a(1, 0, 0, 1, 1, 1, 4, 0);
        #1;
        chk("t3_stall", ifa.stall_o, 0);
        step();
        id_a(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t3_fwd_a", ifa.fwd_a_o, 2'b00);
        chk("t3_fwd_b", ifa.fwd_b_o, 2'b00);
        step(); step(); step();

        // ---- 4: beq ; lw r3 ; add r5,r3,r3 with branch taken in MEM ----
        id_a(1, 1, 2, 1, 1, 0, 0, 0);
        step();
        id_a(1, 1, 0, 1, 0, 1, 3, 1);
        step();
        id_a(1, 3, 3, 1, 1, 1, 5, 0);
        ifa.mem_br_taken_i = 1'b1;
        #1;
        chk("t4_flush", ifa.flush_o, 1);
        chk("t4_stall", ifa.stall_o, 0);
        step();
        ifa.mem_br_taken_i = 1'b0;
        id_a(1, 3, 3, 1, 1, 1, 7, 0);
        #1;
        chk("t4_flush_drop", ifa.flush_o,     0);
        chk("t4_flush_cnt",  ifa.flush_cnt_o, 1);
        chk("t4_stall_cnt",  ifa.stall_cnt_o, 1);
        chk("t4_post_stall", ifa.stall_o,     0);
        step();
        id_a(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        // A surviving lw in MEM would have produced a MEM/WB forward here.
        chk("t4_post_fwd_a", ifa.fwd_a_o, 2'b00);
        chk("t4_post_fwd_b", ifa.fwd_b_o, 2'b00);
        step(); step(); step();

        // ---- 5: instance B, no forwarding, no write-through ----
        chk("b_rst_stall_cnt", ifb.stall_cnt_o, 0);
        rst_b = 1'b0;
        id_b(1, 1, 2, 1, 1, 1, 3, 0);
        step();
        id_b(1, 3, 4, 1, 1, 1, 6, 0);
        #1;
        chk("t5_stall_ex",  ifb.stall_o, 1);
        chk("t5_fwd_a_ex",  ifb.fwd_a_o, 2'b00);
        step();
        #1;
        chk("t5_stall_mem", ifb.stall_o,     1);
        chk("t5_cnt1",      ifb.stall_cnt_o, 1);
        chk("t5_fwd_b_mem", ifb.fwd_b_o,     2'b00);
        step();
        #1;
        chk("t5_stall_wb",  ifb.stall_o,     1);
        chk("t5_cnt2",      ifb.stall_cnt_o, 2);
        step();
        #1;
        chk("t5_released",  ifb.stall_o,     0);
        chk("t5_cnt3",      ifb.stall_cnt_o, 3);
        step();
        id_b(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("t5_fwd_a", ifb.fwd_a_o, 2'b00);
        chk("t5_fwd_b", ifb.fwd_b_o, 2'b00);
        step(); step(); step();

        // ---- 6: saturation at 2-bit max, then reset mid-stall ----
        id_b(1, 1, 2, 1, 1, 1, 3, 0);
        step();
        id_b(1, 3, 4, 1, 1, 1, 6, 0);
        #1;
        chk("t6_stall", ifb.stall_o, 1);
        step();
        #1;
        chk("t6_sat_cnt1", ifb.stall_cnt_o, 3);
        chk("t6_stall2",   ifb.stall_o,     1);
        step();
        #1;
        chk("t6_sat_cnt2", ifb.stall_cnt_o, 3);
        rst_b = 1'b1;
        #1;
        chk("t6_rst_stall_now", ifb.stall_o, 0);
        step();
        #1;
        chk("t6_rst_cnt",   ifb.stall_cnt_o, 0);
        chk("t6_rst_stall", ifb.stall_o,     0);
        rst_b = 1'b0;
        #1;
        chk("t6_empty_pipe", ifb.stall_o, 0);
        step();
        #1;
        chk("t6_post_cnt",   ifb.stall_cnt_o, 0);
        chk("t6_post_stall", ifb.stall_o,     0);
        id_b(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pipe_hazard_unit

`default_nettype wire
